// File: rtl/lfsr_seq_checker_pkg.sv
// Shared types and the 4-bit xin-driven LFSR next-state function used by the
// checker and by any model of the upstream stage.
package lfsr_chk_pkg;

  localparam int LFSR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HUNT = 2'd1,
    ST_LOCK = 2'd2
  } chk_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s,
                                                  input logic              x);
    return {s[3] ^ x, s[3] ^ s[0], s[1], s[2] ^ s[3]};
  endfunction

endpackage

// File: rtl/lfsr_seq_checker_if.sv
// Beat stream into the checker plus the status it reports back.
interface lfsr_seq_checker_if #(
  parameter int ERR_W = 8
);
  logic             clr;
  logic             in_valid;
  logic [3:0]       in_state;
  logic             in_xin;
  logic             locked;
  logic             mismatch;
  logic [ERR_W-1:0] err_cnt;
  logic [1:0]       fsm_state;

  modport master (
    output clr, in_valid, in_state, in_xin,
    input  locked, mismatch, err_cnt, fsm_state
  );

  modport slave (
    input  clr, in_valid, in_state, in_xin,
    output locked, mismatch, err_cnt, fsm_state
  );
endinterface

// File: rtl/lfsr_seq_checker.sv
// Predicts each LFSR beat from the previous one and runs a hunt/lock FSM with
// flywheel recovery; reports lock, per-beat mismatch and a saturating error count.
module lfsr_seq_checker
  import lfsr_chk_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int ERR_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  lfsr_seq_checker_if.slave  bus
);

  chk_state_e        state_q, state_d;
  logic [LFSR_W-1:0] ref_state_q, ref_state_d;
  logic              ref_xin_q, ref_xin_d;
  logic [3:0]        good_cnt_q, good_cnt_d;
  logic [3:0]        bad_cnt_q, bad_cnt_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic              mismatch_d;
  logic              locked_q, mismatch_q;
  logic [1:0]        fsm_state_q;

  logic [LFSR_W-1:0] pred;
  logic              match;

  assign pred  = lfsr_next(ref_state_q, ref_xin_q);
  assign match = (bus.in_state == pred);

  always_comb begin
    state_d     = state_q;
    ref_state_d = ref_state_q;
    ref_xin_d   = ref_xin_q;
    good_cnt_d  = good_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    err_cnt_d   = err_cnt_q;
    mismatch_d  = 1'b0;

    if (bus.clr) begin
      state_d     = ST_IDLE;
      ref_state_d = '0;
      ref_xin_d   = 1'b0;
      good_cnt_d  = '0;
      bad_cnt_d   = '0;
      err_cnt_d   = '0;
    end else if (bus.in_valid) begin
      case (state_q)
        ST_IDLE: begin
          ref_state_d = bus.in_state;
          ref_xin_d   = bus.in_xin;
          state_d     = ST_HUNT;
        end
        ST_HUNT: begin
          ref_state_d = bus.in_state;
          ref_xin_d   = bus.in_xin;
          if (match) begin
            if (good_cnt_q + 4'd1 == 4'(LOCK_CNT)) begin
              state_d    = ST_LOCK;
              good_cnt_d = '0;
              bad_cnt_d  = '0;
            end else begin
              good_cnt_d = good_cnt_q + 4'd1;
            end
          end else begin
            good_cnt_d = '0;
            mismatch_d = 1'b1;
          end
        end
        ST_LOCK: begin
          if (match) begin
            bad_cnt_d   = '0;
            ref_state_d = bus.in_state;
            ref_xin_d   = bus.in_xin;
          end else begin
            mismatch_d = 1'b1;
            if (err_cnt_q != '1)
              err_cnt_d = err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
            // Flywheel: continue from the prediction so one bad beat costs one mismatch.
            ref_xin_d = bus.in_xin;
            if (bad_cnt_q + 4'd1 == 4'(UNLOCK_CNT)) begin
              state_d     = ST_HUNT;
              bad_cnt_d   = '0;
              ref_state_d = bus.in_state;
            end else begin
              bad_cnt_d   = bad_cnt_q + 4'd1;
              ref_state_d = pred;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ref_state_q <= '0;
      ref_xin_q   <= 1'b0;
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ref_state_q <= ref_state_d;
      ref_xin_q   <= ref_xin_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      locked_q    <= 1'b0;
      mismatch_q  <= 1'b0;
      fsm_state_q <= 2'd0;
    end else begin
      locked_q    <= (state_d == ST_LOCK);
      mismatch_q  <= mismatch_d;
      fsm_state_q <= state_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.mismatch  = mismatch_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.fsm_state = fsm_state_q;

endmodule

// File: doc/lfsr_seq_checker.md
Name: lfsr_seq_checker

Overview:
- Downstream consumer of the 4-bit xin-driven LFSR stage.
- Each valid beat carries the LFSR state and the xin bit applied at the edge that produces the next state.
- Predicts the next state, compares it against the next beat, and runs a hunt/lock state machine with flywheel recovery.
- Reports lock status, per-beat mismatch pulses and a saturating error count to the test/status logic.

Parameters:
- LOCK_CNT, 4: consecutive matches in HUNT needed to enter LOCK (legal range 1..15).
- UNLOCK_CNT, 3: consecutive mismatches in LOCK that drop back to HUNT (legal range 1..15).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- clr  in  1  synchronous clear: go to IDLE, zero all counters.
- in_valid  in  1  beat qualifier.
- in_state  in  4  observed LFSR state S_k, bit 3 is the MSB.
- in_xin  in  1  xin applied with S_k; defines S_k+1 = F(S_k, x_k).
- locked  out  1  high while the FSM is in LOCK.
- mismatch  out  1  one-cycle pulse: last compared beat mismatched.
- err_cnt  out  ERR_W  mismatches seen while in LOCK, saturating.
- fsm_state  out  2  IDLE=0, HUNT=1, LOCK=2.

Behaviour:
- Next-state function: F(s,x) = {s[3]^x, s[3]^s[0], s[1], s[2]^s[3]}.
- Internal registers: ref_state[3:0], ref_xin, good_cnt[3:0], bad_cnt[3:0].
- Async reset (rst_n low): FSM=IDLE; locked=0, mismatch=0, err_cnt=0; ref and counters =0.
- clr=1 at an edge has the same effect as reset and overrides in_valid in that cycle.
- All outputs are registered. The response to a beat sampled at edge N is visible after edge N.
- in_valid=0: no state change; mismatch returns to 0.
- Compare: pred = F(ref_state, ref_xin); match = (in_state == pred).
- IDLE, valid beat: ref <= {in_state, in_xin}; go to HUNT; no compare.
- HUNT, match: good_cnt++. If good_cnt+1 == LOCK_CNT, go to LOCK and clear good_cnt and bad_cnt.
- HUNT, any beat: ref <= observed {in_state, in_xin}.
- HUNT, mismatch: good_cnt <= 0; mismatch pulse; err_cnt unchanged; ref is re-seeded from the beat.
- LOCK, match: bad_cnt <= 0; ref <= observed.
- LOCK, mismatch (flywheel): mismatch pulse; err_cnt++ saturating at all-ones; bad_cnt++; ref <= {pred, in_xin}.
  - Using the prediction keeps a single corrupted beat from causing a second mismatch.
  - If bad_cnt+1 == UNLOCK_CNT, go to HUNT, clear bad_cnt, and set ref <= observed beat.
- locked is high exactly when FSM==LOCK. fsm_state mirrors the FSM register.
- err_cnt never wraps; only reset or clr zero it.
- The all-zero state with xin=0 is legal (F=0000) and checked normally; no special case.
- Reset or clr mid-lock: immediate IDLE. The next valid beat is treated as the first reference.

Decomposition:
- Package lfsr_chk_pkg:
  - state enum IDLE/HUNT/LOCK (2 bits).
  - constant LFSR_W=4.
  - function lfsr_next(s,x) implementing F, shared with the upstream model and the scoreboard.
- No sub-module needed. The predictor is a function call, and the FSM plus counters live in one always block with a separate output register block.

Test Plan:
- Reset/idle: rst_n=0 then 1, no valid → fsm_state=0, locked=0, err_cnt=0, mismatch=0.
- Clean lock, LOCK_CNT=4:
  - Stimulus: beats (0000,1),(1000,0),(1101,1),(0000,1),(1000,0).
  - Expected: HUNT after beat 1; LOCK after beat 5 (4 matches); mismatch never asserted.
- Single corrupt beat in LOCK:
  - Stimulus: after lock, send 1111 where 1101 is expected, then continue the true sequence (0000,1).
  - Expected: one mismatch pulse; err_cnt=1; bad_cnt returns to 0; locked stays 1.
- Loss of lock, UNLOCK_CNT=3: three consecutive wrong states → err_cnt=3; fsm_state=HUNT after the third beat; locked=0.
- HUNT reseed: in HUNT after 2 matches, send a wrong beat → good_cnt=0, mismatch pulse, err_cnt unchanged. Then 4 correct transitions → LOCK.
- Saturation and clear:
  - Stimulus: ERR_W=2; force 5 mismatches in LOCK (UNLOCK_CNT=15).
  - Expected: err_cnt=3 (saturated). Then clr=1 for one cycle → IDLE, err_cnt=0.
  - Also assert rst_n low mid-beat → outputs 0 asynchronously.
